// File: rtl/xfer_arbiter_if.sv
// Requester channel into the transfer arbiter: one descriptor handshake plus
// the completion/error pulses returned to that requester.
interface xfer_arbiter_if #(
  parameter int ADDR_WR_W = 5,
  parameter int ADDR_RD_W = 4
);
  logic                 valid;
  logic [ADDR_WR_W-1:0] src;
  logic [ADDR_RD_W-1:0] dst;
  logic [ADDR_WR_W-1:0] len;
  logic                 ready;
  logic                 done;
  logic                 err;

  modport master (output valid, src, dst, len, input  ready, done, err);
  modport slave  (input  valid, src, dst, len, output ready, done, err);
endinterface

// File: rtl/xfer_arbiter.sv
// Two-requester round-robin arbiter that range-checks a transfer descriptor,
// starts the RAM_IN -> RAM_OUT engine and reports done/err to the owner.
module xfer_arbiter #(
  parameter int ADDR_WR_W = 5,
  parameter int ADDR_RD_W = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  xfer_arbiter_if.slave        req0,
  xfer_arbiter_if.slave        req1,
  output logic                 eng_start,
  output logic [ADDR_WR_W-1:0] eng_src,
  output logic [ADDR_RD_W-1:0] eng_dst,
  output logic [ADDR_WR_W-1:0] eng_len,
  input  logic                 eng_done,
  output logic                 busy,
  output logic                 last_grant,
  output logic                 timeout_flag
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] ARM   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Range arithmetic is widened so src + 2*len cannot wrap.
  localparam int SUM_W = ((ADDR_WR_W > ADDR_RD_W) ? ADDR_WR_W : ADDR_RD_W) + 2;
  localparam logic [ADDR_WR_W-1:0] LEN_MAX = ADDR_WR_W'(2 ** (ADDR_WR_W - 1));
  localparam logic [SUM_W-1:0]     SRC_LIM = SUM_W'(2 ** ADDR_WR_W);
  localparam logic [SUM_W-1:0]     DST_LIM = SUM_W'(2 ** ADDR_RD_W);

  logic [2:0]       state;
  logic             ptr;
  logic             resp_err;
  logic [CNT_W-1:0] cnt;

  logic                 sel;
  logic                 handshake;
  logic                 legal;
  logic [ADDR_WR_W-1:0] sel_src;
  logic [ADDR_RD_W-1:0] sel_dst;
  logic [ADDR_WR_W-1:0] sel_len;
  logic [SUM_W-1:0]     src_end;
  logic [SUM_W-1:0]     dst_end;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    sel = req1.valid;
    if (req0.valid && req1.valid) sel = ptr;
    handshake = (state == IDLE) && (req0.valid || req1.valid);
    sel_src   = sel ? req1.src : req0.src;
    sel_dst   = sel ? req1.dst : req0.dst;
    sel_len   = sel ? req1.len : req0.len;
    src_end   = SUM_W'(sel_src) + (SUM_W'(sel_len) << 1);
    dst_end   = SUM_W'(sel_dst) + SUM_W'(sel_len);
    legal     = (sel_len != '0) && (sel_len <= LEN_MAX) &&
                (src_end <= SRC_LIM) && (dst_end <= DST_LIM);
  end

  assign req0.ready = (state == IDLE) && req0.valid && !sel;
  assign req1.ready = (state == IDLE) && req1.valid &&  sel;

  assign req0.done = (state == RESP) && !resp_err && !last_grant;
  assign req0.err  = (state == RESP) &&  resp_err && !last_grant;
  assign req1.done = (state == RESP) && !resp_err &&  last_grant;
  assign req1.err  = (state == RESP) &&  resp_err &&  last_grant;

  assign eng_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  // NOTE: synchronous reset inside the clocked block; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      last_grant   <= 1'b0;
      resp_err     <= 1'b0;
      cnt          <= '0;
      timeout_flag <= 1'b0;
      eng_src      <= '0;
      eng_dst      <= '0;
      eng_len      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            eng_src    <= sel_src;
            eng_dst    <= sel_dst;
            eng_len    <= sel_len;
            last_grant <= sel;
            ptr        <= ~sel;
            resp_err   <= ~legal;
            state      <= legal ? ISSUE : RESP;
          end
        end
        ISSUE: state <= ARM;
        ARM: begin
          // A stale engine done is deliberately ignored here.
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            resp_err <= 1'b0;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            resp_err     <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_arbiter.sv
// Scoreboard bench for xfer_arbiter: descriptors push expected engine starts and
// responses; a negedge monitor pops and compares them as the DUT produces them.
module tb_xfer_arbiter;

  localparam int TIMEOUT = 16;

  typedef struct {
    bit owner;
    int src;
    int dst;
    int len;
    int cycle;
  } start_t;

  typedef struct {
    bit owner;
    bit err;
    bit tmo;
    int cycle;
  } resp_t;

  logic       clk;
  logic       rst;
  logic       eng_start;
  logic [4:0] eng_src;
  logic [3:0] eng_dst;
  logic [4:0] eng_len;
  logic       eng_done;
  logic       busy;
  logic       last_grant;
  logic       timeout_flag;

  xfer_arbiter_if #(.ADDR_WR_W(5), .ADDR_RD_W(4)) r0 ();
  xfer_arbiter_if #(.ADDR_WR_W(5), .ADDR_RD_W(4)) r1 ();

  xfer_arbiter #(.ADDR_WR_W(5), .ADDR_RD_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (r0),
    .req1         (r1),
    .eng_start    (eng_start),
    .eng_src      (eng_src),
    .eng_dst      (eng_dst),
    .eng_len      (eng_len),
    .eng_done     (eng_done),
    .busy         (busy),
    .last_grant   (last_grant),
    .timeout_flag (timeout_flag)
  );

  start_t start_q[$];
  resp_t  resp_q[$];
  int     lat_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     exp_flag = 1'b0;
  int     t_a;
  int     t_b;
  int     t_c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: done rises lat cycles after the start cycle (lat 0 = never)
  // and, like a level, stays high until two cycles into the next start.
  initial begin
    int k;
    int lat;
    bit active;
    k = 0;
    lat = 0;
    active = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        k = 0;
        active = 1'b1;
        if (lat_q.size() > 0) lat = lat_q.pop_front();
        else lat = 0;
      end else if (active) begin
        k++;
      end
      if (active && k >= 2) eng_done = (lat > 0) && (k >= lat);
    end
  end

  // Monitor: engine starts and requester pulses against the scoreboard.
  initial forever begin
    start_t s;
    resp_t  e;
    bit     d;
    bit     x;
    @(negedge clk);
    if (r0.ready && r1.ready) check("ready_onehot", 1, 0);
    if (eng_start) begin
      if (start_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        s = start_q.pop_front();
        check("start_cycle", cyc, s.cycle);
        check("eng_src", eng_src, s.src);
        check("eng_dst", eng_dst, s.dst);
        check("eng_len", eng_len, s.len);
        check("last_grant", last_grant, s.owner);
      end
    end
    for (int n = 0; n < 2; n++) begin
      d = (n == 1) ? r1.done : r0.done;
      x = (n == 1) ? r1.err  : r0.err;
      if (d || x) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = resp_q.pop_front();
          if (e.tmo) exp_flag = 1'b1;
          check("resp_owner", n, e.owner);
          check("resp_is_err", x, e.err);
          check("resp_done_err_excl", d && x, 0);
          check("resp_cycle", cyc, e.cycle);
          check("timeout_flag", timeout_flag, exp_flag);
        end
      end
    end
  end

  // Raise valid, wait (bounded) for ready, then queue the expected outcome.
  task automatic send(input bit n, input int src, input int dst, input int len,
                      input int lat, output int t_hs);
    bit     got;
    bit     legal;
    start_t s;
    resp_t  e;
    got = 1'b0;
    t_hs = -1;
    if (n) begin
      r1.src = 5'(src); r1.dst = 4'(dst); r1.len = 5'(len); r1.valid = 1'b1;
    end else begin
      r0.src = 5'(src); r0.dst = 4'(dst); r0.len = 5'(len); r0.valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      #1;
      if ((n ? r1.ready : r0.ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("handshake_wait", 0, 1);
    end else begin
      t_hs = cyc;
      legal = (len >= 1) && (len <= 16) && (src + 2 * len - 1 <= 31) && (dst + len - 1 <= 15);
      e.owner = n;
      if (!legal) begin
        e.err = 1'b1; e.tmo = 1'b0; e.cycle = t_hs + 1;
      end else begin
        s.owner = n; s.src = src; s.dst = dst; s.len = len; s.cycle = t_hs + 1;
        start_q.push_back(s);
        lat_q.push_back(lat);
        if (lat >= 2 && lat - 2 <= TIMEOUT - 1) begin
          e.err = 1'b0; e.tmo = 1'b0; e.cycle = t_hs + lat + 2;
        end else begin
          e.err = 1'b1; e.tmo = 1'b1; e.cycle = t_hs + 3 + TIMEOUT;
        end
      end
      resp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (n) r1.valid = 1'b0;
    else   r0.valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (resp_q.size() + start_q.size()) > 0; i++) @(negedge clk);
    check(tag, resp_q.size() + start_q.size(), 0);
    @(negedge clk);
    check("busy_after_drain", busy, 0);
  endtask

  task automatic flush_model();
    start_q.delete();
    resp_q.delete();
    lat_q.delete();
    exp_flag = 1'b0;
  endtask

  task automatic check_cleared();
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_src", eng_src, 0);
    check("rst_eng_dst", eng_dst, 0);
    check("rst_eng_len", eng_len, 0);
    check("rst_last_grant", last_grant, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    check("rst_pulses", {r0.done, r0.err, r1.done, r1.err}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    r0.valid = 1'b0; r0.src = '0; r0.dst = '0; r0.len = '0;
    r1.valid = 1'b0; r1.src = '0; r1.dst = '0; r1.len = '0;
    repeat (2) @(negedge clk);
    check_cleared();
    rst = 1'b0;
    @(negedge clk);

    // Single full-length request; done lands in the last WAIT cycle.
    send(0, 0, 0, 16, 17, t_a);
    drain("drain_single");

    // Simultaneous requests after reset: req0 first, stale done through req1's ISSUE/ARM.
    do_reset();
    fork
      send(0, 1, 2, 3, 5, t_a);
      send(1, 4, 5, 6, 8, t_b);
    join
    check("rr_req0_first", (t_a >= 0) && (t_b > t_a), 1);
    drain("drain_simul");

    // Range checks: illegal descriptors and legal edge cases.
    send(1, 30, 0, 2, 5, t_a);
    drain("drain_src_ovf");
    send(0, 0, 0, 0, 5, t_a);
    drain("drain_len0");
    send(0, 0, 12, 5, 5, t_a);
    drain("drain_dst_ovf");
    send(0, 0, 0, 17, 5, t_a);
    drain("drain_len17");
    send(1, 30, 15, 1, 3, t_a);
    drain("drain_edge_legal");
    send(0, 16, 0, 8, 2, t_a);
    drain("drain_min_lat");

    // Watchdog expiry, then a normal transfer with the flag still set.
    send(0, 2, 3, 4, 0, t_a);
    drain("drain_timeout");
    send(1, 0, 0, 8, 6, t_a);
    drain("drain_after_timeout");

    // Reset during WAIT with both requesters pending; req0 owned the aborted one.
    send(0, 0, 0, 4, 0, t_a);
    repeat (5) @(negedge clk);
    fork
      send(0, 5, 1, 2, 3, t_b);
      send(1, 6, 2, 3, 4, t_c);
      begin
        rst = 1'b1;
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        check_cleared();
        check("rst_ptr0_ready0", r0.ready, 1);
        check("rst_ptr0_ready1", r1.ready, 0);
      end
    join
    check("rst_req0_first", (t_b >= 0) && (t_c > t_b), 1);
    drain("drain_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
